// File: rtl/cpu_seq_if.sv
// Instruction-memory fetch port of cpu_seq.
// master: the sequencer (drives the address and the request).
// slave : the instruction memory (returns the acknowledge and the word).
interface cpu_seq_if;
    logic [3:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;

    modport master (output imem_addr, output imem_req, input imem_ack, input imem_data);
    modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/cpu_seq.sv
// cpu_seq: FETCH / DECODE / EXEC / HALT sequencer for a 4-bit-PC toy CPU.
// It fetches one 8-bit instruction ({opcode, operand}), decodes it, and then
// pulses the datapath strobes for the single EXEC cycle.
// Optional build macro CPU_SEQ_STEP_EN adds the 'step' input and a STEP
// state that parks the sequencer after each EXEC until step is seen high.
//
// Fetch handshake (imem_req / imem_ack):
//   A fetch completes on a rising edge where imem_req and imem_ack are both
//   high. Once imem_req is raised, it stays high and imem_addr stays stable
//   until that edge. imem_ack is ignored whenever imem_req is low.
module cpu_seq (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CPU_SEQ_STEP_EN
    input  logic             step,
`endif
    cpu_seq_if.master        imem,
    output logic [3:0]       imm,
    output logic             aload,
    output logic             bload,
    output logic             dsel,
    output logic             rload,
    output logic             opsel,
    output logic             jump,
    output logic             halted,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        HALT   = 3'd3
`ifdef CPU_SEQ_STEP_EN
        ,
        STEP   = 3'd4
`endif
    } state_t;

    localparam logic [3:0] OP_JUMP = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       req;
    // Strobe vector, packed as {aload, bload, dsel, rload, opsel, jump}.
    logic [5:0] stb;

    // Opcode to strobe pattern; unlisted opcodes are NOPs.
    function automatic logic [5:0] decode_op(input logic [3:0] op);
        case (op)
            4'h0:    return 6'b100000;  // load A from immediate
            4'h1:    return 6'b010000;  // load B from immediate
            4'h2:    return 6'b101000;  // load A from data bus
            4'h3:    return 6'b011000;  // load B from data bus
            4'h4:    return 6'b000100;  // R <= A + B
            4'h5:    return 6'b000110;  // R <= A - B
            OP_JUMP: return 6'b000001;  // PC <= operand
            default: return 6'b000000;
        endcase
    endfunction

    assign imem.imem_addr = pc;
    assign imem.imem_req  = req;
    assign aload     = stb[5];
    assign bload     = stb[4];
    assign dsel      = stb[3];
    assign rload     = stb[2];
    assign opsel     = stb[1];
    assign jump      = stb[0];
    assign state_dbg = state;

    // Sequencer FSM with registered request, operand, strobes and halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= 4'h0;
            ir     <= 8'h00;
            imm    <= 4'h0;
            stb    <= 6'b000000;
            halted <= 1'b0;
            req    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!req) begin
                        // First cycle after reset release: raise the request.
                        req <= 1'b1;
                    end else if (imem.imem_ack) begin
                        ir    <= imem.imem_data;
                        req   <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    imm <= ir[3:0];
                    if (ir[7:4] == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        stb   <= decode_op(ir[7:4]);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    stb <= 6'b000000;
                    pc  <= stb[0] ? imm : pc + 4'd1;
`ifdef CPU_SEQ_STEP_EN
                    state <= STEP;
`else
                    // Request goes high together with FETCH entry.
                    req   <= 1'b1;
                    state <= FETCH;
`endif
                end
`ifdef CPU_SEQ_STEP_EN
                STEP: begin
                    if (step) begin
                        req   <= 1'b1;
                        state <= FETCH;
                    end
                end
`endif
                HALT: begin
                    // Absorbing until rst_n.
                    state <= HALT;
                end
                default: begin
                    stb   <= 6'b000000;
                    req   <= 1'b0;
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Testbench for cpu_seq: directed programs plus randomized programs and
// randomized imem_ack, checked against an instruction-level model.
module tb_cpu_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef CPU_SEQ_STEP_EN
    localparam int PER = 4;   // FETCH, DECODE, EXEC, STEP with step high
    logic step = 1'b1;
`else
    localparam int PER = 3;   // FETCH, DECODE, EXEC
`endif

    cpu_seq_if bus ();

    logic [3:0] imm;
    logic       aload, bload, dsel, rload, opsel, jump, halted;
    logic [2:0] state_dbg;
    logic [5:0] stb_v;
    assign stb_v = {aload, bload, dsel, rload, opsel, jump};

    cpu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CPU_SEQ_STEP_EN
        .step      (step),
`endif
        .imem      (bus),
        .imm       (imm),
        .aload     (aload),
        .bload     (bload),
        .dsel      (dsel),
        .rload     (rload),
        .opsel     (opsel),
        .jump      (jump),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    // ---------------- instruction memory ----------------
    logic [7:0] mem [16];
    int         ack_mode = 0;   // 0: ack tied high, 1: random, 2: ack low

    always_comb bus.imem_data = mem[bus.imem_addr];

    always @(posedge clk) begin
        #2;
        case (ack_mode)
            0:       bus.imem_ack = 1'b1;
            1:       bus.imem_ack = ($urandom_range(0, 3) != 0);
            default: bus.imem_ack = 1'b0;
        endcase
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Instruction-set view: strobes that each opcode must raise.
    function automatic logic [5:0] ref_strobes(input logic [3:0] op);
        logic [5:0] s;
        s = '0;
        if (op == 4'h0 || op == 4'h2) s[5] = 1'b1;          // aload
        if (op == 4'h1 || op == 4'h3) s[4] = 1'b1;          // bload
        if (op == 4'h2 || op == 4'h3) s[3] = 1'b1;          // dsel
        if (op == 4'h4 || op == 4'h5) s[2] = 1'b1;          // rload
        if (op == 4'h5)               s[1] = 1'b1;          // opsel (sub)
        if (op == 4'h6)               s[0] = 1'b1;          // jump
        return s;
    endfunction

    logic [9:0] exp_q[$];       // {strobes, operand} expected in EXEC
    int         exp_cyc_q[$];   // cycle number of that EXEC
    logic [3:0] m_pc = 4'h0;
    bit         m_halted = 1'b0;
    int         halt_cyc = 0;
    int         req_due = -1;
    bit         prev_wait = 1'b0;
    bit         chk_lat = 1'b1;
    int         cyc = 0;
    int         n_acc = 0;

    always @(negedge clk) begin
        logic [9:0] e;
        logic [3:0] op;
        if (!rst_n) begin
            m_pc = 4'h0; m_halted = 1'b0; req_due = -1; prev_wait = 1'b0; cyc = 0;
            exp_q.delete(); exp_cyc_q.delete();
        end else begin
            cyc++;
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                e = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                check("exec_strobes", 32'(stb_v), 32'(e[9:4]));
                check("exec_imm", 32'(imm), 32'(e[3:0]));
            end else begin
                check("idle_strobes", 32'(stb_v), 32'd0);
            end
            if (m_halted && cyc >= halt_cyc) begin
                check("halted", 32'(halted), 32'd1);
                check("halt_req", 32'(bus.imem_req), 32'd0);
                check("halt_pc", 32'(bus.imem_addr), 32'(m_pc));
            end else begin
                check("not_halted", 32'(halted), 32'd0);
            end
            if (chk_lat && req_due == cyc) check("refetch_latency", 32'(bus.imem_req), 32'd1);
            if (prev_wait) check("req_held", 32'(bus.imem_req), 32'd1);
            prev_wait = bus.imem_req && !bus.imem_ack;
            if (bus.imem_req && bus.imem_ack) begin
                check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
                op = bus.imem_data[7:4];
                n_acc++;
                if (op == 4'hF) begin
                    m_halted = 1'b1;
                    halt_cyc = cyc + 2;
                end else begin
                    exp_q.push_back({ref_strobes(op), bus.imem_data[3:0]});
                    exp_cyc_q.push_back(cyc + 2);
                    req_due = cyc + PER;
                    m_pc = (op == 4'h6) ? bus.imem_data[3:0] : m_pc + 4'd1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_nops();
        for (int i = 0; i < 16; i++) mem[i] = {4'h7 + 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("req_low_after_release", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1 check("first_req", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("rst_pc", 32'(bus.imem_addr), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_strobes", 32'(stb_v), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        release_reset();
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;

        // Single immediate load.
        fill_nops();
        mem[0] = 8'h0A;
        ack_mode = 0;
        do_reset();
        run(2);
        check("ld_aload", 32'(aload), 32'd1);
        check("ld_imm", 32'(imm), 32'hA);
        run(1);
        check("ld_aload_off", 32'(aload), 32'd0);
        check("ld_pc_after", 32'(bus.imem_addr), 32'd1);

        // Straight-line program: one instruction every PER cycles.
        fill_nops();
        mem[0] = 8'h23; mem[1] = 8'h31; mem[2] = 8'h45; mem[3] = 8'h55;
        do_reset();
        n_acc = 0;
        run(12);
        check("prog_rate", 32'(n_acc), 32'((12 + PER - 1) / PER));

        // Jump to 0xE, NOPs at 0xE/0xF, PC wraps to 0.
        fill_nops();
        mem[2] = 8'h6E;
        do_reset();
        n_acc = 0;
        run(5 * PER + 1);
        check("jump_fetches", 32'(n_acc), 32'd6);
        check("pc_wrap", 32'(bus.imem_addr), 32'd0);

        // Memory stalls for 5 cycles in FETCH.
        fill_nops();
        ack_mode = 2;
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(bus.imem_req), 32'd1);
            check("stall_pc", 32'(bus.imem_addr), 32'd0);
            check("stall_strobes", 32'(stb_v), 32'd0);
            if (i < 4) run(1);
        end
        check("stall_no_accept", 32'(n_acc), 32'd0);
        ack_mode = 0;
        run(3);
        check("stall_resume", 32'(n_acc), 32'd1);

        // Halt at address 1, then restart through reset.
        fill_nops();
        mem[0] = 8'h00; mem[1] = 8'hF0;
        do_reset();
        run(PER + 6);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_req_off", 32'(bus.imem_req), 32'd0);
        check("halt_pc_frozen", 32'(bus.imem_addr), 32'd1);
        do_reset();
        check("restart_pc", 32'(bus.imem_addr), 32'd0);
        check("restart_halted", 32'(halted), 32'd0);

`ifdef CPU_SEQ_STEP_EN
        // Park in STEP, then release exactly one instruction.
        fill_nops();
        mem[0] = 8'h01; mem[1] = 8'h12;
        chk_lat = 1'b0;
        step = 1'b0;
        do_reset();
        n_acc = 0;
        run(12);
        check("step_parked", 32'(n_acc), 32'd1);
        check("step_parked_req", 32'(bus.imem_req), 32'd0);
        step = 1'b1;
        run(1);
        step = 1'b0;
        run(12);
        check("step_one_more", 32'(n_acc), 32'd2);
        step = 1'b1;
        chk_lat = 1'b1;
`endif

        // Random programs with random memory latency.
        fill_random();
        ack_mode = 1;
        do_reset();
        run(200);

        // Reset asserted in the middle of an EXEC cycle.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            run(1);
            if (stb_v != 6'd0) found = 1'b1;
        end
        check("exec_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midexec_strobes", 32'(stb_v), 32'd0);
        check("midexec_pc", 32'(bus.imem_addr), 32'd0);
        check("midexec_req", 32'(bus.imem_req), 32'd0);
        release_reset();
        run(100);

        // Random program that may halt somewhere.
        fill_random();
        mem[$urandom_range(0, 15)] = 8'hF0;
        do_reset();
        run(150);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
